apb_xfer_sequencer: RTL and testbench

APB-side controller for the AHB-to-APB bridge, in the rclk domain. It pops {write, addr, data} entries from the async FIFO read port and drives APB SETUP/ACCESS phases with Pready wait states. It decodes Paddr to a one-hot Psel, returns read data, and aborts stalled transfers with a timeout. It replaces the free-running transfer/Psel sequencing in top_bridge.

---
 rtl/bridge_pkg.sv | 34 +++
 rtl/apb_slave_decode.sv | 27 ++
 rtl/apb_xfer_sequencer.sv | 127 ++++++++++++
 tb/tb_apb_xfer_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the APB side of the AHB-to-APB bridge.
// The FIFO entry layout is {write, addr, data}, with data in the low bits.
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Data field always starts at bit 0 of an entry.
   localparam int DATA_LSB = 0;

   // Position of the write flag (entry MSB) for a given address/data width.
   function automatic int entry_wr_bit(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   // The address field sits directly above the data field.
   function automatic int entry_addr_lsb(input int data_w);
      return data_w;
   endfunction

   // Ceiling log2 for n >= 2.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Address to one-hot slave select. The select field is the clog2(NSLV)
// bits starting at SEL_LSB; all selects are held low while sel_en is low.
module apb_slave_decode
   import bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int NSLV    = 4,
   parameter int SEL_LSB = 28
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              sel_en,
   output logic [NSLV-1:0]   psel
);

   localparam int SEL_W = clog2(NSLV);

   logic [SEL_W-1:0] sel_idx;

   assign sel_idx = addr[SEL_LSB +: SEL_W];

   // One-hot decode of the slave index, gated by the enable.
   always_comb begin
      psel = '0;
      if (sel_en) psel[sel_idx] = 1'b1;
   end

endmodule

// File: rtl/apb_xfer_sequencer.sv
// APB master sequencer in the rclk domain. Pops {write, addr, data} entries
// from a first-word-fall-through FIFO and runs one APB SETUP/ACCESS transfer
// per entry, with Pready wait states and a stall timeout.
//
// FIFO handshake: the head entry is valid whenever rempty is low; rinc is a
// single-cycle pop that is only ever raised together with rempty low, and the
// entry is consumed at the same rising edge that latches it into Paddr/Pdata.
module apb_xfer_sequencer
   import bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 16
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic                     transfer,
   input  logic                     rempty,
   input  logic [ADDR_W+DATA_W:0]   fifo_rdata,
   output logic                     rinc,
   input  logic                     Pready,
   input  logic                     Pslverr,
   input  logic [DATA_W-1:0]        Prdata,
   output logic [NSLV-1:0]          Psel,
   output logic                     Penable,
   output logic                     Pwrite,
   output logic [ADDR_W-1:0]        Paddr,
   output logic [DATA_W-1:0]        Pdata,
   output logic [DATA_W-1:0]        rdata_temp,
   output logic                     rd_valid,
   output logic                     err,
   output logic                     busy,
   output logic [15:0]              xfer_cnt
);

   localparam int         WR_BIT   = entry_wr_bit(ADDR_W, DATA_W);
   localparam int         ADDR_LSB = entry_addr_lsb(DATA_W);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   apb_state_e state, state_nxt;
   logic [7:0] to_cnt;
   logic       complete;
   logic       abort_to;
   logic       launch;

   // Transfer events: completion, stall abort, and start of the next entry.
   always_comb begin
      complete = (state == ACCESS) && Pready;
      abort_to = (state == ACCESS) && !Pready && (to_cnt == TO_LAST);
      launch   = transfer && !rempty && ((state == IDLE) || complete);
   end

   // State register.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; a completing transfer can chain straight into SETUP.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS: begin
            if (complete)      state_nxt = launch ? SETUP : IDLE;
            else if (abort_to) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; rinc is held off while reset is asserted.
   always_comb begin
      rinc    = launch && rrst_n;
      Penable = (state == ACCESS);
      busy    = (state != IDLE);
   end

   apb_slave_decode #(
      .ADDR_W  (ADDR_W),
      .NSLV    (NSLV),
      .SEL_LSB (SEL_LSB)
   ) u_decode (
      .addr   (Paddr),
      .sel_en (busy),
      .psel   (Psel)
   );

   // Latch the FIFO head as the new transfer; values hold between transfers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         Pwrite <= 1'b0;
         Paddr  <= '0;
         Pdata  <= '0;
      end else if (launch) begin
         Pwrite <= fifo_rdata[WR_BIT];
         Paddr  <= fifo_rdata[ADDR_LSB +: ADDR_W];
         Pdata  <= fifo_rdata[DATA_LSB +: DATA_W];
      end
   end

   // Completion side effects: read capture, status pulses, transfer count.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rdata_temp <= '0;
         rd_valid   <= 1'b0;
         err        <= 1'b0;
         xfer_cnt   <= '0;
      end else begin
         rd_valid <= complete && !Pwrite;
         err      <= (complete && Pslverr) || abort_to;
         if (complete && !Pwrite) rdata_temp <= Prdata;
         if (complete)            xfer_cnt   <= xfer_cnt + 16'd1;
      end
   end

   // Stall counter: cleared as each transfer starts, counts ACCESS waits.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)                          to_cnt <= '0;
      else if (launch)                      to_cnt <= '0;
      else if ((state == ACCESS) && !Pready) to_cnt <= to_cnt + 8'd1;
   end

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Bench for apb_xfer_sequencer: per-cycle vector table, directed multi-cycle
// sequences, and a randomized run against a transaction-level APB model.
module tb_apb_xfer_sequencer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int EW = 1 + AW + DW;

   // ---------------- clock / reset ----------------
   logic rclk = 1'b0;
   logic rrst_n;
   always #5 rclk = ~rclk;

   logic          transfer, rempty, rinc, Pready, Pslverr;
   logic [EW-1:0] fifo_rdata;
   logic [DW-1:0] Prdata, Pdata, rdata_temp;
   logic [NS-1:0] Psel;
   logic          Penable, Pwrite, rd_valid, err, busy;
   logic [AW-1:0] Paddr;
   logic [15:0]   xfer_cnt;

   apb_xfer_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .SEL_LSB(28), .TIMEOUT(16)
   ) dut (
      .rclk(rclk), .rrst_n(rrst_n), .transfer(transfer), .rempty(rempty),
      .fifo_rdata(fifo_rdata), .rinc(rinc), .Pready(Pready), .Pslverr(Pslverr),
      .Prdata(Prdata), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pdata(Pdata), .rdata_temp(rdata_temp), .rd_valid(rd_valid),
      .err(err), .busy(busy), .xfer_cnt(xfer_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input logic [31:0] a);
      logic [3:0] r;
      r = 4'b0001 << a[29:28];
      return r;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic          tr, emp;
      logic [EW-1:0] head;
      logic          rdy, serr;
      logic [31:0]   prd;
      logic          x_rinc;
      logic [3:0]    x_psel;
      logic          x_pen, x_pwr;
      logic [31:0]   x_paddr, x_pdata;
      logic          x_busy, x_rdv, x_err;
      logic [15:0]   x_cnt;
      logic [31:0]   x_rtmp;
   } vec_t;

   function automatic vec_t mk(
      input logic tr, input logic emp, input logic [EW-1:0] head,
      input logic rdy, input logic serr, input logic [31:0] prd,
      input logic rn, input logic [3:0] ps, input logic pe, input logic pw,
      input logic [31:0] pa, input logic [31:0] pd, input logic bz,
      input logic rv, input logic er, input logic [15:0] cn, input logic [31:0] rt);
      vec_t v;
      v.tr = tr; v.emp = emp; v.head = head; v.rdy = rdy; v.serr = serr; v.prd = prd;
      v.x_rinc = rn; v.x_psel = ps; v.x_pen = pe; v.x_pwr = pw; v.x_paddr = pa;
      v.x_pdata = pd; v.x_busy = bz; v.x_rdv = rv; v.x_err = er; v.x_cnt = cn;
      v.x_rtmp = rt;
      return v;
   endfunction

   task automatic apply_row(input vec_t v, input int idx);
      @(negedge rclk);
      transfer = v.tr; rempty = v.emp; fifo_rdata = v.head;
      Pready = v.rdy; Pslverr = v.serr; Prdata = v.prd;
      #1;
      chk($sformatf("row%0d", idx),
          128'({rinc, Psel, Penable, Pwrite, Paddr, Pdata, busy, rd_valid, err, xfer_cnt, rdata_temp}),
          128'({v.x_rinc, v.x_psel, v.x_pen, v.x_pwr, v.x_paddr, v.x_pdata, v.x_busy,
                v.x_rdv, v.x_err, v.x_cnt, v.x_rtmp}));
   endtask

   // ---------------- FIFO model driver ----------------
   logic [EW-1:0] fifo_q[$];
   logic [EW-1:0] exp_q[$];
   bit            pop_pend = 0;

   task automatic cycle_fifo(input logic tr, input logic rdy, input logic serr, input logic [31:0] prd);
      @(negedge rclk);
      if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
      transfer   = tr;
      rempty     = (fifo_q.size() == 0);
      fifo_rdata = rempty ? '0 : fifo_q[0];
      Pready     = rdy;
      Pslverr    = serr;
      Prdata     = prd;
      #1;
      pop_pend = rinc;
      if (rinc) chk("pop_on_empty", 128'(rempty), 128'(0));
   endtask

   // ---------------- test ----------------
   vec_t tbl[17];
   logic [EW-1:0] W, R, E, D1, D2;
   int busy_n, rinc_n, acc;
   bit done;

   // random-phase model state
   bit            m_active, m_first, last_done, last_wr, last_serr;
   logic [31:0]   last_prd;
   logic [EW-1:0] m_cur;
   int            waits, exp_cnt;

   initial begin
      rrst_n = 1'b0; transfer = 0; rempty = 1; fifo_rdata = '0;
      Pready = 0; Pslverr = 0; Prdata = '0;
      repeat (3) @(negedge rclk);
      #1;
      chk("reset_state",
          128'({rinc, Psel, Penable, Pwrite, Paddr, Pdata, busy, rd_valid, err, xfer_cnt, rdata_temp}),
          128'(0));
      rrst_n = 1'b1;

      // Directed per-cycle table: single write, waited read, slave error, idle cases.
      W = {1'b1, 32'h0000_0004, 32'h1111_1111};
      R = {1'b0, 32'h2000_0008, 32'h0000_0000};
      E = {1'b1, 32'h3000_0010, 32'hCAFE_F00D};
      tbl[0]  = mk(1,0,W,1,0,0,            1,4'h0,0,0,32'h0,0,0,0,0,0,0);
      tbl[1]  = mk(0,1,0,1,0,0,            0,4'h1,0,1,32'h4,32'h1111_1111,1,0,0,0,0);
      tbl[2]  = mk(0,1,0,1,0,0,            0,4'h1,1,1,32'h4,32'h1111_1111,1,0,0,0,0);
      tbl[3]  = mk(0,1,0,0,0,0,            0,4'h0,0,1,32'h4,32'h1111_1111,0,0,0,1,0);
      tbl[4]  = mk(1,0,R,0,0,0,            1,4'h0,0,1,32'h4,32'h1111_1111,0,0,0,1,0);
      tbl[5]  = mk(0,1,0,1,0,0,            0,4'h4,0,0,32'h2000_0008,0,1,0,0,1,0);
      tbl[6]  = mk(0,1,0,0,0,32'h1234_5678,0,4'h4,1,0,32'h2000_0008,0,1,0,0,1,0);
      tbl[7]  = mk(0,1,0,0,0,32'h1234_5678,0,4'h4,1,0,32'h2000_0008,0,1,0,0,1,0);
      tbl[8]  = mk(0,1,0,0,0,32'h1234_5678,0,4'h4,1,0,32'h2000_0008,0,1,0,0,1,0);
      tbl[9]  = mk(0,1,0,1,0,32'hDEAD_BEEF,0,4'h4,1,0,32'h2000_0008,0,1,0,0,1,0);
      tbl[10] = mk(0,1,0,0,0,0,            0,4'h0,0,0,32'h2000_0008,0,0,1,0,2,32'hDEAD_BEEF);
      tbl[11] = mk(1,0,E,0,0,0,            1,4'h0,0,0,32'h2000_0008,0,0,0,0,2,32'hDEAD_BEEF);
      tbl[12] = mk(0,1,0,1,1,0,            0,4'h8,0,1,32'h3000_0010,32'hCAFE_F00D,1,0,0,2,32'hDEAD_BEEF);
      tbl[13] = mk(0,1,0,1,1,0,            0,4'h8,1,1,32'h3000_0010,32'hCAFE_F00D,1,0,0,2,32'hDEAD_BEEF);
      tbl[14] = mk(0,1,0,0,0,0,            0,4'h0,0,1,32'h3000_0010,32'hCAFE_F00D,0,0,1,3,32'hDEAD_BEEF);
      tbl[15] = mk(1,1,0,0,0,0,            0,4'h0,0,1,32'h3000_0010,32'hCAFE_F00D,0,0,0,3,32'hDEAD_BEEF);
      tbl[16] = mk(0,0,E,1,0,0,            0,4'h0,0,1,32'h3000_0010,32'hCAFE_F00D,0,0,0,3,32'hDEAD_BEEF);
      for (int i = 0; i < 17; i++) apply_row(tbl[i], i);

      // Back-to-back: three queued writes, always ready.
      fifo_q.push_back({1'b1, 32'h0000_0100, 32'hA000_0001});
      fifo_q.push_back({1'b1, 32'h1000_0104, 32'hA000_0002});
      fifo_q.push_back({1'b1, 32'h3000_0108, 32'hA000_0003});
      busy_n = 0; rinc_n = 0;
      for (int c = 0; c < 8; c++) begin
         cycle_fifo(1, 1, 0, 0);
         busy_n += int'(busy);
         rinc_n += int'(rinc);
      end
      chk("b2b_busy_cycles", 128'(busy_n), 128'(6));
      chk("b2b_rinc_pulses", 128'(rinc_n), 128'(3));
      chk("b2b_xfer_cnt", 128'(xfer_cnt), 128'(6));

      // Timeout: Pready stuck low.
      fifo_q.push_back({1'b0, 32'h1000_0040, 32'h0});
      cycle_fifo(1, 0, 0, 0);
      chk("to_launch", 128'(rinc), 128'(1));
      acc = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         cycle_fifo(0, 0, 0, 0);
         if (Penable) acc++;
         else if (acc > 0) done = 1;
      end
      chk("to_terminated", 128'(done), 128'(1));
      chk("to_access_cycles", 128'(acc), 128'(16));
      chk("to_abort_outputs", 128'({err, Psel, busy, rd_valid}), 128'({1'b1, 4'h0, 1'b0, 1'b0}));
      chk("to_cnt_unchanged", 128'(xfer_cnt), 128'(6));
      cycle_fifo(0, 0, 0, 0);
      chk("to_err_one_cycle", 128'(err), 128'(0));
      fifo_q.push_back({1'b1, 32'h2000_0044, 32'h5555_AAAA});
      cycle_fifo(1, 1, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      chk("post_to_setup", 128'({Psel, Penable}), 128'({4'b0100, 1'b0}));
      cycle_fifo(0, 1, 0, 0);
      cycle_fifo(0, 0, 0, 0);
      chk("post_to_cnt", 128'({xfer_cnt, err}), 128'({16'd7, 1'b0}));

      // transfer dropped during the transfer: it completes, nothing more pops.
      D1 = {1'b1, 32'h0000_0020, 32'h0BAD_0001};
      D2 = {1'b1, 32'h1000_0024, 32'h0BAD_0002};
      fifo_q.push_back(D1);
      fifo_q.push_back(D2);
      cycle_fifo(1, 1, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      cycle_fifo(0, 0, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      busy_n = 0; rinc_n = 0;
      for (int c = 0; c < 4; c++) begin
         cycle_fifo(0, 1, 0, 0);
         busy_n += int'(busy);
         rinc_n += int'(rinc);
      end
      chk("drop_no_pop", 128'(rinc_n), 128'(0));
      chk("drop_idle", 128'(busy_n), 128'(0));
      chk("drop_cnt", 128'(xfer_cnt), 128'(8));
      chk("drop_fifo_left", 128'(fifo_q.size()), 128'(1));

      // Randomized run against a transaction-level APB model.
      m_active = 0; m_first = 0; last_done = 0; last_wr = 0; last_serr = 0;
      last_prd = '0; m_cur = D1; waits = 0; exp_cnt = 8;
      for (int c = 0; c < 400; c++) begin
         logic tr, rdy, serr, exp_pen, exp_done, exp_rinc;
         logic [31:0] prd;
         logic [3:0]  exp_psel;
         if (c < 320 && $urandom_range(0, 9) < 4 && fifo_q.size() < 6)
            fifo_q.push_back({1'($urandom_range(0, 1)), 32'($urandom()), 32'($urandom())});
         tr   = (c >= 320) ? 1'b1 : ($urandom_range(0, 9) != 0);
         rdy  = (waits >= 6) ? 1'b1 : ($urandom_range(0, 9) < 6);
         serr = ($urandom_range(0, 9) == 0);
         prd  = $urandom();
         cycle_fifo(tr, rdy, serr, prd);

         if (last_done) begin
            chk("rnd_status", 128'({err, rd_valid}), 128'({last_serr, !last_wr}));
            if (!last_wr) chk("rnd_rdata", 128'(rdata_temp), 128'(last_prd));
            chk("rnd_cnt", 128'(xfer_cnt), 128'(exp_cnt));
         end else begin
            chk("rnd_quiet", 128'({err, rd_valid}), 128'(0));
         end

         exp_pen  = m_active && !m_first;
         exp_done = exp_pen && rdy;
         exp_rinc = (!m_active || exp_done) && tr && (fifo_q.size() != 0);
         exp_psel = m_active ? onehot(m_cur[63:32]) : 4'h0;
         chk("rnd_ctrl", 128'({rinc, busy, Penable}), 128'({exp_rinc, m_active, exp_pen}));
         chk("rnd_bus", 128'({Psel, Pwrite, Paddr, Pdata}), 128'({exp_psel, m_cur}));

         last_done = exp_done;
         if (exp_done) begin
            last_wr   = m_cur[64];
            last_serr = serr;
            last_prd  = prd;
            exp_cnt++;
            if (exp_q.size() > 0) exp_q.delete(0);
         end
         if (exp_pen && !rdy) waits++;
         else waits = 0;
         if (exp_rinc) begin
            m_cur = fifo_q[0];
            exp_q.push_back(fifo_q[0]);
            m_active = 1; m_first = 1;
         end else if (exp_done) begin
            m_active = 0;
         end else if (m_active) begin
            m_first = 0;
         end
      end
      chk("rnd_drained", 128'({fifo_q.size() == 0, exp_q.size() == 0, m_active}), 128'(3'b110));

      // Reset asserted during ACCESS, with a pop otherwise pending.
      fifo_q.push_back({1'b0, 32'h3000_0000, 32'h0});
      fifo_q.push_back({1'b1, 32'h0000_0030, 32'h7777_0001});
      cycle_fifo(1, 0, 0, 0);
      cycle_fifo(0, 0, 0, 0);
      cycle_fifo(0, 0, 0, 0);
      chk("rst_pre_access", 128'({Penable, busy}), 128'(2'b11));
      @(negedge rclk);
      if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
      transfer = 1; rempty = 0; fifo_rdata = fifo_q[0];
      rrst_n = 1'b0;
      #1;
      chk("rst_async",
          128'({rinc, Psel, Penable, Pwrite, Paddr, Pdata, busy, rd_valid, err, xfer_cnt, rdata_temp}),
          128'(0));
      @(negedge rclk);
      transfer = 0;
      rrst_n = 1'b1;
      pop_pend = 0;
      cycle_fifo(0, 1, 0, 0);
      chk("rst_after", 128'({busy, xfer_cnt, fifo_q.size() == 1}), 128'({1'b0, 16'd0, 1'b1}));
      cycle_fifo(1, 1, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      cycle_fifo(0, 1, 0, 0);
      chk("rst_resume_cnt", 128'({xfer_cnt, busy}), 128'({16'd1, 1'b0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
